// File: rtl/pipe_pkg.sv
// pipe_pkg: per-stage pipeline bundle types, their widths and the skid buffer state encoding
package pipe_pkg;
  typedef struct packed {
    logic predict_taken;
  } if_id_ctrl_t;
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } if_id_data_t;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic       jump;
    logic [4:0] alu_control;
  } id_ex_ctrl_t;
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] sign_imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
  } id_ex_data_t;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ex_mem_ctrl_t;
  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
  } ex_mem_data_t;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;
  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
  } mem_wb_data_t;
  localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
  localparam int IF_ID_DATA_W  = $bits(if_id_data_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins, increment stops at all-ones
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  // count register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with flush, optional 2-entry skid buffer and bubble counter
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              bubble_clr
);
  localparam int EW = CTRL_W + DATA_W;
  logic          accept, pop;
  logic [EW-1:0] head, in_ent;
  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign in_ent = {in_ctrl, in_data};
  generate
    if (SKID == 0) begin : g_reg
      logic          valid_q, valid_d;
      logic [EW-1:0] ent_q, ent_d;
      // load on accept, empty on pop, everything cleared on flush
      always_comb begin
        valid_d = flush ? 1'b0 : accept ? 1'b1 : pop ? 1'b0 : valid_q;
        ent_d   = flush ? '0 : accept ? in_ent : pop ? '0 : ent_q;
      end
      // single holding register
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          valid_q <= 1'b0;
          ent_q   <= '0;
        end else begin
          valid_q <= valid_d;
          ent_q   <= ent_d;
        end
      // ready combinationally follows downstream when the register is occupied
      always_comb begin
        in_ready  = ~valid_q | out_ready;
        out_valid = valid_q;
        head      = ent_q;
      end
    end else begin : g_skid
      skid_state_e   state_q, state_d;
      logic          rdy_q, rdy_d;
      logic [EW-1:0] main_q, main_d, skid_q, skid_d;
      // state, entries and the registered ready
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          state_q <= EMPTY;
          rdy_q   <= 1'b0;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          rdy_q   <= rdy_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      // next state and entry movement; main always holds the oldest entry
      always_comb begin
        state_d = flush ? EMPTY :
                  (state_q == EMPTY) ? (accept ? ONE : EMPTY) :
                  (state_q == ONE)   ? ((accept && !pop) ? FULL : (!accept && pop) ? EMPTY : ONE) :
                                       (pop ? ONE : FULL);
        main_d  = flush ? '0 :
                  (pop || state_q == EMPTY) ? ((state_q == FULL) ? skid_q : accept ? in_ent : '0) :
                  main_q;
        skid_d  = flush ? '0 :
                  (state_q == ONE && accept && !pop) ? in_ent :
                  (state_q == FULL && pop) ? '0 : skid_q;
        rdy_d   = state_d != FULL;
      end
      // outputs come straight from registers, so no out_ready-to-in_ready path exists
      always_comb begin
        in_ready  = rdy_q;
        out_valid = state_q != EMPTY;
        head      = main_q;
      end
    end
  endgenerate
  assign out_ctrl = head[EW-1 -: CTRL_W];
  assign out_data = head[DATA_W-1:0];
  sat_counter #(.W(CNT_W)) u_bubble (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(out_ready & ~out_valid),
    .clr_i(bubble_clr),
    .cnt_o(bubble_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized and directed checks of both buffer modes against a queue-based model
module tb_pipe_stage_buf;
  localparam int CW = 12;
  localparam int DW = 85;
  logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bubble_clr = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          s_ir, s_ov, z_ir, z_ov;
  logic [CW-1:0] s_oc, z_oc;
  logic [DW-1:0] s_od, z_od;
  logic [3:0]    s_bc;
  logic [15:0]   z_bc;
  always #5 clk = ~clk;
  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready),
    .out_ctrl(s_oc), .out_data(s_od), .bubble_cnt(s_bc), .bubble_clr(bubble_clr));
  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_pass (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_ir),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(z_ov), .out_ready(out_ready),
    .out_ctrl(z_oc), .out_data(z_od), .bubble_cnt(z_bc), .bubble_clr(bubble_clr));
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t q1[$];
  ent_t q0[$];
  bit   r1 = 1'b0;
  int   c1 = 0, c0 = 0;
  int   n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask
  task automatic model_reset();
    q1.delete();
    q0.delete();
    r1 = 1'b0;
    c1 = 0;
    c0 = 0;
  endtask
  task automatic model_update();
    ent_t e;
    bit   p, a;
    if (rst_n) begin
      e = {in_ctrl, in_data};
      p = q1.size() > 0 && out_ready;
      a = in_valid && r1;
      c1 = bubble_clr ? 0 : (out_ready && q1.size() == 0 && c1 < 15) ? c1 + 1 : c1;
      if (p) void'(q1.pop_front());
      if (a) q1.push_back(e);
      if (flush) q1.delete();
      r1 = q1.size() < 2;
      p = q0.size() > 0 && out_ready;
      a = in_valid && (q0.size() == 0 || out_ready);
      c0 = bubble_clr ? 0 : (out_ready && q0.size() == 0 && c0 < 65535) ? c0 + 1 : c0;
      if (p) void'(q0.pop_front());
      if (a) q0.push_back(e);
      if (flush) q0.delete();
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask
  task automatic rnd_data();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    in_data = r[DW-1:0];
  endtask
  always @(negedge clk) begin : cmp
    ent_t h1, h0;
    h1 = q1.size() > 0 ? q1[0] : '0;
    h0 = q0.size() > 0 ? q0[0] : '0;
    chk("skid out_valid", 128'(s_ov), 128'(q1.size() > 0));
    chk("skid out_ctrl", 128'(s_oc), 128'(h1.c));
    chk("skid out_data", 128'(s_od), 128'(h1.d));
    chk("skid in_ready", 128'(s_ir), 128'(r1));
    chk("skid bubble_cnt", 128'(s_bc), 128'(c1));
    chk("pass out_valid", 128'(z_ov), 128'(q0.size() > 0));
    chk("pass out_ctrl", 128'(z_oc), 128'(h0.c));
    chk("pass out_data", 128'(z_od), 128'(h0.d));
    chk("pass in_ready", 128'(z_ir), 128'(q0.size() == 0 || out_ready));
    chk("pass bubble_cnt", 128'(z_bc), 128'(c0));
  end
  initial begin
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("ready after release", 128'(s_ir), 128'(1));
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_ctrl = CW'(i); out_ready = 1'b1; rnd_data();
      cyc();
      chk("stream ctrl", 128'(s_oc), 128'(i));
      chk("stream ready", 128'(s_ir), 128'(1));
    end
    in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    chk("stream bubbles", 128'(s_bc), 128'(1));
    chk("stream last", 128'(s_oc), 128'(12'h005));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h0A1; rnd_data();
    cyc();
    in_ctrl = 12'h0B2; rnd_data();
    cyc();
    chk("full ready", 128'(s_ir), 128'(0));
    chk("full head", 128'(s_oc), 128'(12'h0A1));
    in_ctrl = 12'h0C3; rnd_data();
    cyc();
    chk("C refused", 128'(s_ir), 128'(0));
    chk("C head A", 128'(s_oc), 128'(12'h0A1));
    out_ready = 1'b1;
    cyc();
    chk("drain B", 128'(s_oc), 128'(12'h0B2));
    cyc();
    chk("drain C", 128'(s_oc), 128'(12'h0C3));
    in_valid = 1'b0;
    cyc();
    chk("drain empty", 128'(s_ov), 128'(0));
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h0A1; rnd_data();
    cyc();
    in_ctrl = 12'h0B2; rnd_data();
    cyc();
    flush = 1'b1; in_ctrl = 12'h0C3; rnd_data();
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush valid", 128'(s_ov), 128'(0));
    chk("flush ctrl", 128'(s_oc), 128'(0));
    chk("flush data", 128'(s_od), 128'(0));
    chk("flush ready", 128'(s_ir), 128'(1));
    cyc();
    chk("flush no C3", 128'(s_ov), 128'(0));
    in_valid = 1'b1; in_ctrl = 12'h111; rnd_data();
    cyc();
    chk("pass held", 128'(z_oc), 128'(12'h111));
    chk("pass stalled ready", 128'(z_ir), 128'(0));
    out_ready = 1'b1; in_ctrl = 12'h222; rnd_data();
    #1;
    chk("pass comb ready", 128'(z_ir), 128'(1));
    cyc();
    chk("pass replaced", 128'(z_oc), 128'(12'h222));
    in_valid = 1'b0;
    repeat (20) cyc();
    chk("sat value", 128'(s_bc), 128'(15));
    cyc();
    chk("sat hold", 128'(s_bc), 128'(15));
    bubble_clr = 1'b1;
    cyc();
    bubble_clr = 1'b0;
    chk("clr", 128'(s_bc), 128'(0));
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 32) == 0;
      bubble_clr = ($urandom % 64) == 0;
      in_ctrl = CW'($urandom);
      rnd_data();
      cyc();
    end
    flush = 1'b0; bubble_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h0A1; rnd_data();
    cyc();
    in_ctrl = 12'h0B2; rnd_data();
    cyc();
    in_valid = 1'b0;
    chk("pre-reset full", 128'(s_ov), 128'(1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async valid", 128'(s_ov), 128'(0));
    chk("async ctrl", 128'(s_oc), 128'(0));
    chk("async data", 128'(s_od), 128'(0));
    chk("async ready", 128'(s_ir), 128'(0));
    chk("async cnt", 128'(s_bc), 128'(0));
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post-reset empty", 128'(s_ov), 128'(0));
    chk("post-reset ready", 128'(s_ir), 128'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register, the successor to the fixed-field ID/EX latch.
- Carries one control bundle and one data bundle between two pipeline stages using a valid/ready handshake.
- Supports flush (bubble insertion) and an optional 2-entry skid mode, so a stall from downstream does not form a combinational ready path back upstream.
- Counts bubble cycles for CPI instrumentation.
- Instanced between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- CTRL_W, 12: width of the control bundle (RegWrite, MemtoReg, MemWrite, ALUControl, ...). Zeroed on flush.
- DATA_W, 85: width of the data bundle (operands, register indices, immediate).
- SKID, 1: 0 selects a single register with combinational ready; 1 selects a 2-entry skid buffer with registered ready.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous kill of every held entry.
- in_valid, input, 1: upstream stage presents an entry.
- in_ready, output, 1: this block accepts the entry this cycle.
- in_ctrl, input, CTRL_W: control bundle.
- in_data, input, DATA_W: data bundle.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream consumes the head this cycle.
- out_ctrl, output, CTRL_W: head control; zero when out_valid=0.
- out_data, output, DATA_W: head data; zero when out_valid=0.
- bubble_cnt, output, CNT_W: saturating count of cycles with out_ready=1 and out_valid=0.
- bubble_clr, input, 1: synchronous clear of bubble_cnt.

Behaviour:
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Reset (rst_n=0, asynchronous):
  - out_valid=0; out_ctrl=0; out_data=0; bubble_cnt=0.
  - Skid entry invalid and zeroed.
  - SKID=1: in_ready=0 while in reset, 1 in the first cycle after release.
- Latency: an accepted entry appears on out_* on the next rising edge. Latency is 1 cycle in both modes.
- SKID=0:
  - in_ready = ~out_valid | out_ready. This is combinational.
  - On accept, the register loads in_*.
  - On pop without accept, the register clears to valid=0 and ctrl/data=0.
  - Otherwise the register holds.
- SKID=1 state machine, entries {main, skid}:
  - EMPTY:
    - accept goes to ONE; main loads the input.
  - ONE:
    - accept & pop stays in ONE; main is replaced by the input.
    - accept & ~pop goes to FULL; the input goes to skid.
    - ~accept & pop goes to EMPTY; main is zeroed.
    - ~accept & ~pop holds.
  - FULL:
    - in_ready=0.
    - pop goes to ONE; skid moves to main and skid is zeroed.
    - ~pop holds.
  - in_ready is a registered signal equal to (state != FULL). There is no combinational out_ready-to-in_ready path.
  - Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush.
- Flush, synchronous, highest priority:
  - Next state EMPTY (SKID=0: out_valid=0).
  - All ctrl and data are zeroed.
  - An input presented in the same cycle is dropped, even though in_ready may read 1.
  - pop in the flush cycle is honoured downstream (head consumed), then cleared.
- Bubble counter:
  - Increments when out_ready & ~out_valid.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - bubble_clr has priority over increment and gives 0 next cycle.
  - Flush does not affect the counter.
- Output invariant: out_valid=0 implies out_ctrl=0 and out_data=0. Downstream may therefore ignore out_valid for side-effecting control.

Decomposition:
- Shared package pipe_pkg holds:
  - typedefs for each stage's ctrl bundle and data bundle (id_ex_ctrl_t, id_ex_data_t, ...).
  - localparams for their widths, which feed CTRL_W and DATA_W.
  - the state encoding for EMPTY/ONE/FULL.
- One natural sub-module: sat_counter (parametrised width, inc, clr, saturate). It is reused by other performance counters.

Test Plan:
- Reset and stream (SKID=1):
  - Stimulus: release rst_n; out_ready=1; push ctrl 0x001..0x005 in consecutive cycles.
  - Response: out_ctrl shows 0x001..0x005 one cycle later each; in_ready stays 1; bubble_cnt=1 (the first empty cycle only).
- Backpressure (SKID=1):
  - Stimulus: hold out_ready=0; push A=0x0A1 and B=0x0B2.
  - Response: state FULL; in_ready=0 on the cycle after B; a third push C is not accepted.
  - Stimulus: out_ready=1.
  - Response: A, then B, then C in order, with no duplicate.
- Flush collision:
  - Stimulus: FULL with A and B; assert flush together with in_valid=1 and in_ctrl=0x0C3.
  - Response: next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; 0x0C3 never appears.
- SKID=0 passthrough:
  - Stimulus: out_valid=1; pulse out_ready=1 and in_valid=1 in the same cycle.
  - Response: in_ready=1 combinationally in that cycle; the new entry replaces the old one next edge.
- Counter saturation:
  - Stimulus: CNT_W=4; hold out_ready=1, in_valid=0 for 20 cycles.
  - Response: bubble_cnt=15 and it holds.
  - Stimulus: bubble_clr=1.
  - Response: 0 on the next cycle.
- Async reset mid-operation:
  - Stimulus: pull rst_n low between clock edges while FULL.
  - Response: out_valid drops immediately without waiting for a clock edge; all outputs zero; after release, state EMPTY.
